// File: rtl/multi_func_pkg.sv
// Shared encodings for the multi-function equivalence checker.
package multi_func_pkg;

  typedef enum logic [1:0] {
    OP_NOR  = 2'b00,
    OP_OR   = 2'b01,
    OP_NAND = 2'b10,
    OP_AND  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    DRAIN = 2'b10,
    DONE  = 2'b11
  } state_e;

endpackage

// File: rtl/multi_func_cell.sv
// One selectable WIDTH-input function built three independent ways.
module multi_func_cell
  import multi_func_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] x,
  input  logic [1:0]       op,
  output logic             y_gate,
  output logic             y_beh,
  output logic             y_df
);

  logic [WIDTH-1:0] or_c;
  logic [WIDTH-1:0] and_c;
  logic             op1_n;
  logic             t_and;
  logic             t_or;
  logic             base;

  // Gate level: OR/AND reduction chains, then a gate mux and optional inversion
  assign or_c[0]  = x[0];
  assign and_c[0] = x[0];

  genvar i;
  generate
    for (i = 1; i < WIDTH; i++) begin : g_chain
      or  u_or  (or_c[i],  or_c[i-1],  x[i]);
      and u_and (and_c[i], and_c[i-1], x[i]);
    end
  endgenerate

  not  u_n1  (op1_n, op[1]);
  and  u_a1  (t_and, and_c[WIDTH-1], op[1]);
  and  u_a2  (t_or,  or_c[WIDTH-1],  op1_n);
  or   u_o1  (base,  t_and, t_or);
  // op[0]=1 passes the reduction, op[0]=0 inverts it
  xnor u_xn  (y_gate, base, op[0]);

  // Behavioural: case on the operation
  always_comb begin
    y_beh = 1'b0;
    case (op)
      OP_NOR:  y_beh = ~(|x);
      OP_OR:   y_beh = |x;
      OP_NAND: y_beh = ~(&x);
      OP_AND:  y_beh = &x;
      default: y_beh = 1'b0;
    endcase
  end

  // Dataflow: continuous-assign reductions
  assign y_df = op[1] ? (op[0] ? (&x) : ~(&x))
                      : (op[0] ? (|x) : ~(|x));

endmodule

// File: rtl/multi_func_equiv_checker.sv
// Self-running sweep that cross-checks three implementations of one function.
module multi_func_equiv_checker
  import multi_func_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned CNT_W   = WIDTH + 1,
  parameter int unsigned ERR_VEC = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op_sel,
  input  logic             inject_err,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [WIDTH-1:0] first_err_vec,
  output logic [WIDTH-1:0] vec
);

  localparam logic [WIDTH-1:0] VEC_LAST = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ERR_V    = WIDTH'(ERR_VEC);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_nxt;
  logic             inj_q, inj_nxt;
  logic             seen_q, seen_nxt;
  logic [WIDTH-1:0] vec_nxt, first_nxt, vec_q;
  logic [CNT_W-1:0] err_nxt;
  logic             busy_nxt, done_nxt, pass_nxt;
  logic             y_gate, y_beh, y_df, y_g_f;
  logic             y_g_q, y_b_q, y_d_q, valid_q;
  logic             mismatch;

  multi_func_cell #(.WIDTH(WIDTH)) u_cell (
    .x      (vec),
    .op     (op_q),
    .y_gate (y_gate),
    .y_beh  (y_beh),
    .y_df   (y_df)
  );

  // Planted fault flips the gate-level result at one vector
  assign y_g_f = y_gate ^ (inj_q && (vec == ERR_V));

  // State and bookkeeping registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      op_q          <= 2'b00;
      inj_q         <= 1'b0;
      seen_q        <= 1'b0;
      vec           <= '0;
      err_count     <= '0;
      first_err_vec <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_nxt;
      inj_q         <= inj_nxt;
      seen_q        <= seen_nxt;
      vec           <= vec_nxt;
      err_count     <= err_nxt;
      first_err_vec <= first_nxt;
      busy          <= busy_nxt;
      done          <= done_nxt;
      pass          <= pass_nxt;
    end
  end

  // Next state, vector walk and mismatch accounting
  always_comb begin
    state_d   = state_q;
    op_nxt    = op_q;
    inj_nxt   = inj_q;
    seen_nxt  = seen_q;
    vec_nxt   = vec;
    err_nxt   = err_count;
    first_nxt = first_err_vec;
    mismatch  = !((y_g_q == y_b_q) && (y_b_q == y_d_q));

    if (valid_q && mismatch) begin
      if (err_count != CNT_MAX) err_nxt = err_count + CNT_W'(1);
      if (!seen_q) begin
        first_nxt = vec_q;
        seen_nxt  = 1'b1;
      end
    end

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = RUN;
          vec_nxt   = '0;
          op_nxt    = op_sel;
          inj_nxt   = inject_err;
          err_nxt   = '0;
          first_nxt = '0;
          seen_nxt  = 1'b0;
        end
      end
      RUN: begin
        if (vec == VEC_LAST) state_d = DRAIN;
        else                 vec_nxt = vec + WIDTH'(1);
      end
      DRAIN:   state_d = DONE;
      default: state_d = IDLE;
    endcase

    busy_nxt = (state_d == RUN) || (state_d == DRAIN);
    done_nxt = (state_d == DONE);
    pass_nxt = done_nxt && (err_nxt == '0);
  end

  // Stage 1: capture the three results for the current vector
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_g_q   <= 1'b0;
      y_b_q   <= 1'b0;
      y_d_q   <= 1'b0;
      vec_q   <= '0;
      valid_q <= 1'b0;
    end else if (state_q == RUN) begin
      y_g_q   <= y_g_f;
      y_b_q   <= y_beh;
      y_d_q   <= y_df;
      vec_q   <= vec;
      valid_q <= 1'b1;
    end else begin
      valid_q <= 1'b0;
    end
  end

endmodule
